// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor (2-bit counter BHT + tagged BTB) with execute-stage
// resolution, table update, mispredict flush/redirect and event counters.
module branch_predict_unit #(
  parameter int          XLEN     = 32,
  parameter int          ENTRIES  = 64,
  parameter int          IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            e_valid,
  input  logic            e_stall,
  input  logic [6:0]      e_op,
  input  logic [2:0]      e_funct3,
  input  logic [XLEN-1:0] e_pc,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_pred_target,
  input  logic            e_zero,
  input  logic            e_lt,
  input  logic            e_ltu,
  output logic            e_flush,
  output logic [XLEN-1:0] e_redirect_pc,
  output logic [1:0]      e_pcsrc,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JALR = 2'b10
  } pcsrc_e;

  logic [1:0]       cnt_q        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
  logic [XLEN-1:0]  btb_target_q [ENTRIES];

  // ---------------- fetch lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx         = f_pc[IDX_W+1:2];
  assign f_tag         = f_pc[XLEN-1:IDX_W+2];
  assign f_hit         = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_pred_taken  = f_hit && cnt_q[f_idx][1];
  assign f_pred_target = f_pred_taken ? btb_target_q[f_idx] : f_pc + XLEN'(4);

  // ---------------- execute resolution ----------------
  logic             active;
  logic             is_br, is_jal, is_jalr, br_legal, br_cond;
  logic             actual_taken, mispredict, counted, tbl_update;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic [1:0]       cnt_cur, cnt_next;
  pcsrc_e           pcsrc;

  assign active  = e_valid && !e_stall;
  assign is_br   = (e_op == OP_BRANCH);
  assign is_jal  = (e_op == OP_JAL);
  assign is_jalr = (e_op == OP_JALR);
  assign e_idx   = e_pc[IDX_W+1:2];
  assign e_tag   = e_pc[XLEN-1:IDX_W+2];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    br_legal = 1'b1;
    br_cond  = 1'b0;
    case (e_funct3)
      3'b000:  br_cond = e_zero;
      3'b001:  br_cond = !e_zero;
      3'b100:  br_cond = e_lt;
      3'b101:  br_cond = !e_lt;
      3'b110:  br_cond = e_ltu;
      3'b111:  br_cond = !e_ltu;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    actual_taken = active && ((is_br && br_legal && br_cond) || is_jal || is_jalr);
    // Aliased predictions on non-control instructions must also be squashed.
    mispredict   = active && ((actual_taken != e_pred_taken) ||
                              (actual_taken && (e_pred_target != e_target)));
    counted      = active && (is_br || is_jal || is_jalr);
    tbl_update   = active && ((is_br && br_legal) || is_jal);

    pcsrc = PCSRC_SEQ;
    if (active && is_jalr)  pcsrc = PCSRC_JALR;
    else if (actual_taken)  pcsrc = PCSRC_BR;
  end

  assign e_flush       = mispredict;
  assign e_redirect_pc = actual_taken ? e_target : e_pc + XLEN'(4);
  assign e_pcsrc       = pcsrc;

  always_comb begin
    cnt_cur  = cnt_q[e_idx];
    cnt_next = cnt_cur;
    if (is_jal)              cnt_next = 2'b11;
    else if (actual_taken)   cnt_next = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'b01;
    else                     cnt_next = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'b01;
  end

  // ---------------- state ----------------
  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
      btb_valid_q   <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (tbl_update) begin
        cnt_q[e_idx] <= cnt_next;
        if (actual_taken) btb_valid_q[e_idx] <= 1'b1;
      end
      if (counted)    br_count      <= br_count + 32'd1;
      if (mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

  // NOTE: tag/target storage is not reset; btb_valid gates every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (tbl_update && actual_taken) begin
      btb_tag_q[e_idx]    <= e_tag;
      btb_target_q[e_idx] <= e_target;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_branch_predict_unit;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        e_valid, e_stall;
  logic [6:0]  e_op;
  logic [2:0]  e_funct3;
  logic [31:0] e_pc, e_target, e_pred_target;
  logic        e_pred_taken, e_zero, e_lt, e_ltu;
  logic        e_flush;
  logic [31:0] e_redirect_pc;
  logic [1:0]  e_pcsrc;
  logic [31:0] br_count, mispred_count;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .e_valid(e_valid), .e_stall(e_stall), .e_op(e_op), .e_funct3(e_funct3),
    .e_pc(e_pc), .e_target(e_target), .e_pred_taken(e_pred_taken),
    .e_pred_target(e_pred_target), .e_zero(e_zero), .e_lt(e_lt), .e_ltu(e_ltu),
    .e_flush(e_flush), .e_redirect_pc(e_redirect_pc), .e_pcsrc(e_pcsrc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt   [N];
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int unsigned m_br, m_mis;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == (pc / (4 * N))) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[m_index(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 1; m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_br = 0; m_mis = 0;
  endtask

  // One execute cycle: drive on the falling edge, check combinational results,
  // then let the rising edge update and check the statistics.
  task automatic step(input bit v, input bit st, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                      input logic [31:0] ptgt, input bit z, input bit lt, input bit ltu,
                      input logic [31:0] fpc);
    bit act, ctrl, legal, taken, mis, upd;
    int i;
    logic [1:0] exp_src;
    @(negedge clk);
    e_valid = v; e_stall = st; e_op = op; e_funct3 = f3; e_pc = pc; e_target = tgt;
    e_pred_taken = pt; e_pred_target = ptgt; e_zero = z; e_lt = lt; e_ltu = ltu;
    f_pc = fpc;
    #1;
    act   = v && !st;
    legal = 1'b1;
    taken = 1'b0;
    case (f3)
      3'd0: taken = z;   3'd1: taken = !z;
      3'd4: taken = lt;  3'd5: taken = !lt;
      3'd6: taken = ltu; 3'd7: taken = !ltu;
      default: legal = 1'b0;
    endcase
    if (op != 7'b1100011) begin taken = 1'b0; legal = 1'b0; end
    if (op == 7'b1101111 || op == 7'b1100111) taken = 1'b1;
    taken = taken && act;
    ctrl  = act && (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111);
    upd   = act && (legal || op == 7'b1101111);
    mis   = act && ((taken != pt) || (taken && ptgt != tgt));
    exp_src = (act && op == 7'b1100111) ? 2'd2 : (taken ? 2'd1 : 2'd0);

    check("f_pred_taken",  {31'd0, f_pred_taken}, {31'd0, m_pred(fpc)});
    check("f_pred_target", f_pred_target, m_pred_tgt(fpc));
    check("e_flush",       {31'd0, e_flush}, {31'd0, mis});
    check("e_pcsrc",       {30'd0, e_pcsrc}, {30'd0, exp_src});
    if (act) check("e_redirect_pc", e_redirect_pc, taken ? tgt : pc + 32'd4);

    @(posedge clk);
    i = m_index(pc);
    if (upd) begin
      if (op == 7'b1101111) m_cnt[i] = 3;
      else if (taken)       m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      else                  m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      if (taken) begin
        m_valid[i] = 1; m_tag[i] = pc / (4 * N); m_tgt[i] = tgt;
      end
    end
    if (ctrl) m_br++;
    if (mis)  m_mis++;
    #1;
    check("br_count",      br_count,      m_br);
    check("mispred_count", mispred_count, m_mis);
  endtask

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;

  initial begin
    logic [31:0] pool [6];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, tgt, ptgt, fpc;
    bit          pt;

    pool = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'h140};
    rst_n = 1'b0; f_pc = 32'h100;
    e_valid = 0; e_stall = 0; e_op = '0; e_funct3 = '0; e_pc = '0; e_target = '0;
    e_pred_taken = 0; e_pred_target = '0; e_zero = 0; e_lt = 0; e_ltu = 0;
    model_reset();
    #12;
    check("rst_pred_taken",  {31'd0, f_pred_taken}, 32'd0);
    check("rst_pred_target", f_pred_target, 32'h104);
    check("rst_br_count",    br_count, 32'd0);
    check("rst_mispred",     mispred_count, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // BEQ taken, predicted not-taken: flush to target and train the entry.
    step(1,0,BR,3'b000,32'h100,32'h80,0,32'h0,1,0,0,32'h100);
    check("beq_trained_taken",  {31'd0, f_pred_taken}, 32'd1);
    check("beq_trained_target", f_pred_target, 32'h80);
    check("beq_mispred_count",  mispred_count, 32'd1);
    // Two not-taken resolutions: 10 -> 01 -> 00.
    step(1,0,BR,3'b000,32'h100,32'h80,1,32'h80,0,0,0,32'h100);
    step(1,0,BR,3'b000,32'h100,32'h80,0,32'h0,0,0,0,32'h100);
    check("beq_weak_nt", {31'd0, f_pred_taken}, 32'd0);
    // Five taken resolutions saturate the counter.
    for (int k = 0; k < 5; k++)
      step(1,0,BR,3'b000,32'h100,32'h80,m_pred(32'h100),m_pred_tgt(32'h100),1,0,0,32'h100);
    check("beq_saturated", {31'd0, f_pred_taken}, 32'd1);
    // BLTU taken, BGE not taken, illegal funct3 counted only.
    step(1,0,BR,3'b110,32'h140,32'h40,0,32'h0,0,0,1,32'h140);
    step(1,0,BR,3'b101,32'h144,32'h44,0,32'h0,0,1,0,32'h144);
    step(1,0,BR,3'b010,32'h148,32'h48,0,32'h0,1,1,1,32'h148);
    // JALR: redirect through pcsrc 10, no table change; 0x200 aliases 0x100's index.
    step(1,0,JALR,3'b000,32'h200,32'h3A0,0,32'h0,0,0,0,32'h200);
    check("jalr_no_alloc", {31'd0, f_pred_taken}, 32'd0);
    // Stalled branch does nothing.
    step(1,1,BR,3'b000,32'h300,32'h30,0,32'h0,1,0,0,32'h300);
    // Aliasing: predicted-taken non-control instruction still mispredicts.
    step(1,0,ALU,3'b000,32'h104,32'h0,1,32'h80,0,0,0,32'h104);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(7))
        0, 1, 2, 3: op = BR;
        4:          op = JAL;
        5:          op = JALR;
        default:    op = ($urandom_range(1) != 0) ? ALU : 7'b0000011;
      endcase
      f3  = 3'($urandom_range(7));
      pc  = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(5)];
      tgt = ($urandom_range(1) != 0) ? pc + 32'h40 : ($urandom & 32'hFFFF_FFFE);
      if ($urandom_range(1) != 0) begin
        pt = m_pred(pc); ptgt = m_pred_tgt(pc);
      end else begin
        pt = 1'($urandom_range(1)); ptgt = ($urandom_range(1) != 0) ? tgt : $urandom;
      end
      fpc = ($urandom_range(1) != 0) ? pc : pool[$urandom_range(5)];
      step($urandom_range(7) != 0, $urandom_range(5) == 0, op, f3, pc, tgt, pt, ptgt,
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), fpc);
    end

    // Train 0x100 again, then assert reset mid-resolution of a taken branch.
    step(1,0,JAL,3'b000,32'h100,32'h80,0,32'h0,0,0,0,32'h100);
    @(negedge clk);
    e_valid = 1; e_stall = 0; e_op = BR; e_funct3 = 3'b000; e_pc = 32'h300;
    e_target = 32'h30; e_pred_taken = 0; e_pred_target = 32'h0; e_zero = 1; f_pc = 32'h100;
    #1;
    check("pre_rst_pred", {31'd0, f_pred_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pred_taken",  {31'd0, f_pred_taken}, 32'd0);
    check("midrst_pred_target", f_pred_target, 32'h104);
    check("midrst_br_count",    br_count, 32'd0);
    check("midrst_mispred",     mispred_count, 32'd0);
    check("midrst_flush_comb",  {31'd0, e_flush}, 32'd1);
    @(posedge clk); #1;
    check("midrst_hold_pred",   {31'd0, f_pred_taken}, 32'd0);
    @(negedge clk);
    e_valid = 0; rst_n = 1'b1; f_pc = 32'h300;
    model_reset();
    #1;
    check("postrst_no_alloc", {31'd0, f_pred_taken}, 32'd0);
    step(1,0,BR,3'b000,32'h300,32'h30,0,32'h0,1,0,0,32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
